// File: rtl/mem_stage.sv
// Memory-access stage: turns EXE/MEM load/store requests into word-aligned, byte-strobed bridge transactions.
// Latency: 0 stall for ALU ops; loads/stores stall 2 + ready/done latency cycles. Backpressure: AXI_MEM_stall holds upstream.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_reg,
    input  logic        MemWrite_reg,
    input  logic        RegWrite_reg,
    input  logic [2:0]  DataWidth_reg,
    input  logic [4:0]  rd_reg,
    input  logic [31:0] aluResult_reg,
    input  logic [31:0] readData2_reg,
    output logic        dm_req,
    output logic        dm_write,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_wstrb,
    output logic [31:0] dm_wdata,
    input  logic        dm_ready,
    input  logic        dm_done,
    input  logic [31:0] dm_rdata,
    output logic        AXI_MEM_stall,
    output logic [4:0]  WB_rd,
    output logic        WB_RegWrite,
    output logic [31:0] WB_writeData
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        memop, is_store;
    logic        req_q, req_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  width_q, width_d;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [4:0]  wb_rd_q;
    logic        wb_regwrite_q;
    logic [31:0] wb_data_q;

    assign memop    = MemRead_reg | MemWrite_reg;
    // A request with both flags set is treated as a load.
    assign is_store = MemWrite_reg & ~MemRead_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (memop)    state_d = S_REQ;
            S_REQ:   if (dm_ready) state_d = S_RESP;
            S_RESP:  if (dm_done)  state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    always_comb begin
        st_wstrb = 4'b1111;
        st_wdata = readData2_reg;
        case (DataWidth_reg[1:0])
            2'b00: begin
                st_wstrb = 4'b0001 << aluResult_reg[1:0];
                st_wdata = {4{readData2_reg[7:0]}};
            end
            2'b01: begin
                st_wstrb = aluResult_reg[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{readData2_reg[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        req_d   = req_q;
        write_d = write_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        off_d   = off_q;
        width_d = width_q;
        case (state_q)
            S_IDLE: if (memop) begin
                req_d   = 1'b1;
                write_d = is_store;
                addr_d  = {aluResult_reg[31:2], 2'b00};
                wstrb_d = is_store ? st_wstrb : 4'b0000;
                wdata_d = is_store ? st_wdata : 32'h0;
                off_d   = aluResult_reg[1:0];
                width_d = DataWidth_reg;
            end
            S_REQ:  if (dm_ready) req_d = 1'b0;
            default: ;
        endcase
    end

    // Completion is only recognised in RESP, so the EXE/MEM entry advances exactly once.
    assign AXI_MEM_stall = memop & ~((state_q == S_RESP) & dm_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= 32'h0;
            wstrb_q <= 4'b0000;
            wdata_q <= 32'h0;
            off_q   <= 2'b00;
            width_q <= 3'b000;
        end else begin
            req_q   <= req_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            width_q <= width_d;
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = dm_rdata[7:0];
            2'd1:    ld_byte = dm_rdata[15:8];
            2'd2:    ld_byte = dm_rdata[23:16];
            default: ld_byte = dm_rdata[31:24];
        endcase
        ld_half = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (width_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = dm_rdata;
        endcase
    end

    // WB holds (not bubbles) while stalled so forwarding to the stalled EXE op stays valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_rd_q       <= 5'd0;
            wb_regwrite_q <= 1'b0;
            wb_data_q     <= 32'h0;
        end else if (!AXI_MEM_stall) begin
            wb_rd_q       <= rd_reg;
            wb_regwrite_q <= RegWrite_reg;
            wb_data_q     <= MemRead_reg ? ld_data : aluResult_reg;
        end
    end

    assign dm_req       = req_q;
    assign dm_write     = write_q;
    assign dm_addr      = addr_q;
    assign dm_wstrb     = wstrb_q;
    assign dm_wdata     = wdata_q;
    assign WB_rd        = wb_rd_q;
    assign WB_RegWrite  = wb_regwrite_q;
    assign WB_writeData = wb_data_q;

endmodule
